// File: rtl/stack_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stack_arbiter: round-robin two-port push/pop sequencer for the 2-bit     |
// | direction stack, with occupancy tracking and overflow/underflow refusal. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module stack_arbiter #(
  parameter int DEPTH      = 256,
  parameter int SETTLE_CYC = 2,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_op,
  input  logic [1:0]    r0_wdata,
  output logic          r0_ack,
  output logic [1:0]    r0_rdata,
  output logic          r0_err,
  input  logic          r1_req,
  input  logic          r1_op,
  input  logic [1:0]    r1_wdata,
  output logic          r1_ack,
  output logic [1:0]    r1_rdata,
  output logic          r1_err,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [1:0]    stk_din,
  input  logic [1:0]    stk_dout,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;       // id of the last granted requester
  logic          id_q, id_d;
  logic          op_q, op_d;
  logic [1:0]    wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [1:0]    res_q, res_d;
  logic [2:0]    settle_q, settle_d;
  logic [CW-1:0] count_q, count_d;
  logic          r0_ack_q, r0_ack_d, r1_ack_q, r1_ack_d;
  logic          r0_err_q, r0_err_d, r1_err_q, r1_err_d;
  logic [1:0]    r0_rdata_q, r0_rdata_d, r1_rdata_q, r1_rdata_d;
  logic          push_q, push_d, pop_q, pop_d;
  logic [1:0]    din_q, din_d;
  logic          busy_q, busy_d;

  logic          w_gnt, w_op, w_err, w_finish;
  logic [1:0]    w_wdata;

  assign w_gnt   = (r0_req && r1_req) ? ~ptr_q : r1_req;
  assign w_op    = w_gnt ? r1_op : r0_op;
  assign w_wdata = w_gnt ? r1_wdata : r0_wdata;
  assign w_err   = w_op ? (count_q == '0) : (count_q == CW'(DEPTH));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    op_d       = op_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    res_d      = res_q;
    settle_d   = settle_q;
    count_d    = count_q;
    r0_ack_d   = 1'b0;
    r1_ack_d   = 1'b0;
    r0_err_d   = r0_err_q;
    r1_err_d   = r1_err_q;
    r0_rdata_d = r0_rdata_q;
    r1_rdata_d = r1_rdata_q;
    push_d     = 1'b0;
    pop_d      = 1'b0;
    din_d      = 2'b00;
    w_finish   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (r0_req || r1_req) begin
          // Strobes are registered, so the refusal decision is made here to
          // have them high during the ISSUE cycle itself.
          id_d    = w_gnt;
          ptr_d   = w_gnt;
          op_d    = w_op;
          wdata_d = w_wdata;
          err_d   = w_err;
          res_d   = 2'b00;
          push_d  = !w_op && !w_err;
          pop_d   = w_op && !w_err;
          din_d   = (!w_op && !w_err) ? w_wdata : 2'b00;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (err_q) begin
          w_finish = 1'b1;
        end else begin
          // Stack read is registered: stk_dout is still the pre-pop top here.
          if (op_q) begin
            res_d   = stk_dout;
            count_d = count_q - CW'(1);
          end else begin
            count_d = count_q + CW'(1);
          end
          settle_d = 3'(SETTLE_CYC - 1);
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_q == 3'd0) w_finish = 1'b1;
        else                  settle_d = settle_q - 3'd1;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (w_finish) begin
      state_d = S_DONE;
      if (id_q) begin
        r1_ack_d   = 1'b1;
        r1_rdata_d = res_q;
        r1_err_d   = err_q;
      end else begin
        r0_ack_d   = 1'b1;
        r0_rdata_d = res_q;
        r0_err_d   = err_q;
      end
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= 1'b1;
      id_q       <= 1'b0;
      op_q       <= 1'b0;
      wdata_q    <= 2'b00;
      err_q      <= 1'b0;
      res_q      <= 2'b00;
      settle_q   <= 3'd0;
      count_q    <= '0;
      r0_ack_q   <= 1'b0;
      r1_ack_q   <= 1'b0;
      r0_err_q   <= 1'b0;
      r1_err_q   <= 1'b0;
      r0_rdata_q <= 2'b00;
      r1_rdata_q <= 2'b00;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      din_q      <= 2'b00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      op_q       <= op_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      res_q      <= res_d;
      settle_q   <= settle_d;
      count_q    <= count_d;
      r0_ack_q   <= r0_ack_d;
      r1_ack_q   <= r1_ack_d;
      r0_err_q   <= r0_err_d;
      r1_err_q   <= r1_err_d;
      r0_rdata_q <= r0_rdata_d;
      r1_rdata_q <= r1_rdata_d;
      push_q     <= push_d;
      pop_q      <= pop_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
    end
  end

  assign r0_ack   = r0_ack_q;
  assign r0_rdata = r0_rdata_q;
  assign r0_err   = r0_err_q;
  assign r1_ack   = r1_ack_q;
  assign r1_rdata = r1_rdata_q;
  assign r1_err   = r1_err_q;
  assign stk_push = push_q;
  assign stk_pop  = pop_q;
  assign stk_din  = din_q;
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign busy     = busy_q;

endmodule
`default_nettype wire

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
Two-port arbiter and sequencer in front of the shared 2-bit direction stack used by the maze-solver datapath. Each requester issues single push or pop transactions through a req/ack handshake. The block grants requesters round-robin, drives the stack's push/pop strobes for exactly one cycle, and waits out the stack's registered read latency before returning pop data. It keeps its own occupancy count so that overflow and underflow are refused with an error, and the stack is never touched in those cases.

Parameters:
DEPTH, 256, stack capacity in entries; count width is $clog2(DEPTH)+1.
SETTLE_CYC, 2, cycles to wait after a stack strobe before the stack's data/empty are trusted; legal values are 1 to 7.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high; the same rst also drives the stack
r0_req  in  1  requester 0 transaction request, held until r0_ack
r0_op  in  1  0 = push, 1 = pop; stable while r0_req is high
r0_wdata  in  2  push data
r0_ack  out  1  one-cycle completion pulse
r0_rdata  out  2  pop data, valid with r0_ack
r0_err  out  1  refused transaction (overflow/underflow), valid with r0_ack
r1_req, r1_op, r1_wdata, r1_ack, r1_rdata, r1_err  same as r0_* for requester 1
stk_push  out  1  stack push strobe
stk_pop  out  1  stack pop strobe
stk_din  out  2  stack write data
stk_dout  in  2  stack top-of-stack data
count  out  $clog2(DEPTH)+1  current occupancy
empty  out  1  count==0
full  out  1  count==DEPTH
busy  out  1  FSM is not in IDLE

Behaviour:
- Reset values: all acks, errs, rdata, stk_push, stk_pop, stk_din, count, full and busy are 0; empty is 1. The round-robin pointer favours r0. The FSM goes to IDLE. A reset asserted mid-transaction aborts it with no ack.
- FSM states are IDLE, ISSUE, SETTLE and DONE, and all outputs are registered.
- IDLE:
  - If any req is high, select the winner, latch its id, op and wdata, and go to ISSUE.
  - If only one req is high, that requester wins.
  - If both are high, the requester not granted last wins. After reset, r0 wins first.
  - Update the pointer on every grant.
- ISSUE (one cycle):
  - Push with count==DEPTH, or pop with count==0: set err, drive no strobe, go to DONE.
  - Push: stk_push=1 and stk_din=wdata for this cycle only; count+1.
  - Pop: stk_pop=1 for this cycle only; capture stk_dout as the result, since it is the top before the pop; count-1.
  - Non-error transactions go to SETTLE.
- SETTLE: hold all strobes at 0 for SETTLE_CYC cycles, counted by an internal down-counter, then go to DONE.
- DONE (one cycle):
  - Pulse the granted requester's ack.
  - Drive its rdata (pop result, or 0 for a push) and its err.
  - The other requester's ack/err stay 0. Go to IDLE.
- rdata and err hold their value until that requester's next ack.
- Latency, measured from the IDLE cycle that accepts req:
  - Success: ack 2+SETTLE_CYC cycles later (4 at the default).
  - Error: ack 2 cycles later.
- A req held high after its ack is treated as a new transaction at the next IDLE. A requester wanting one transaction must drop req in the cycle after ack.
- A req arriving while busy waits; it is never lost and never ignored.
- stk_push and stk_pop are never high together and never high outside ISSUE.
- count never wraps: it is saturated by the error checks. empty and full are combinational decodes of the registered count.

Test Plan:
- Reset, then r0 pushes 2'b01, 2'b10, 2'b11 -> each ack arrives 4 cycles after acceptance; count=3; stk_push is exactly one cycle wide with stk_din matching.
- Then r1 pops three times -> rdata is 11, 10, 01; empty=1 after the third pop; err=0 throughout.
- Pop on empty by r0 -> r0_ack with r0_err=1 two cycles after acceptance, no stk_pop, count stays 0.
- Fill to DEPTH (use DEPTH=4), then push again -> err=1, full=1, count=4, no stk_push.
- r0_req and r1_req held continuously with pushes -> grants alternate r0, r1, r0, r1; the first grant after reset goes to r0; no ack overlap.
- Assert rst during the SETTLE of a push -> all outputs at reset values in the same cycle, no ack; the next transaction completes normally.
